cic_comp_fir: RTL
=================

Name: cic_comp_fir

Overview:
- Time-multiplexed FIR that sits directly downstream of the CIC decimator (cic_decim).
- Consumes the CIC's decimated sample stream (data_o/val_o) and applies droop compensation.
- Uses a single multiplier that iterates over NTAPS taps per input sample.
- Output is rounded, saturated and strobed for the next DDC stage.

Parameters:
- DATA_WIDTH, 16: signed input sample width; equals the CIC DATAOUT_WIDTH.
- OUT_WIDTH, 16: signed output width.
- COEF_WIDTH, 18: signed coefficient width.
- COEF_FRAC, 17: coefficient fractional bits; output = round(sum >> COEF_FRAC).
- NTAPS, 21: number of taps, valid range 2..256.
- ACC_WIDTH, DATA_WIDTH+COEF_WIDTH+log2(NTAPS): accumulator width, computed with the codebase log2 function.

Ports:
- clk_i, input, 1: clock.
- rst_i, input, 1: synchronous reset, active-high.
- en_i, input, 1: clock enable. When low, all state, counters and outputs freeze.
- data_i, input, DATA_WIDTH: signed sample from the CIC.
- val_i, input, 1: sample strobe; connects to the CIC val_o.
- coef_we_i, input, 1: coefficient write strobe.
- coef_addr_i, input, log2(NTAPS): tap index.
- coef_data_i, input, COEF_WIDTH: signed coefficient value.
- data_o, output, OUT_WIDTH: filtered sample; held between strobes.
- val_o, output, 1: one-cycle strobe marking a new data_o.
- busy_o, output, 1: high while a sample is being processed.
- overrun_o, output, 1: one-cycle pulse when an input sample is dropped.

Behaviour:
- Reset values:
  - data_o=0, val_o=0, busy_o=0, overrun_o=0.
  - Delay line cleared to 0; write pointer 0; FSM in IDLE.
  - Coefficients: coef[0]=2^COEF_FRAC-1 (full-scale positive, treated as unity passthrough), all others 0.
- Reset mid-operation: aborts the computation. No val_o is produced for the aborted sample.
- Sample acceptance:
  - An input is accepted only when en_i=1, val_i=1 and state=IDLE.
  - The sample is written into the circular delay line at the write pointer.
  - The write pointer wraps from NTAPS-1 to 0.
- Dropped samples:
  - If val_i=1 and en_i=1 while busy_o=1, the sample is dropped.
  - overrun_o pulses high on the next cycle.
  - The in-flight result is unaffected.
- FSM states: IDLE -> MAC -> ROUND -> OUT -> IDLE. All transitions are qualified by en_i.
  - MAC: NTAPS tap iterations plus multiplier pipeline flush.
  - Accumulation: acc = sum over k of coef[k]*x[n-k], k=0..NTAPS-1, where x[n] is the newest sample.
  - Delay-line index arithmetic wraps modulo NTAPS.
  - Accumulator is cleared at the start of each sample. Full precision; no overflow possible within ACC_WIDTH.
  - ROUND: add 2^(COEF_FRAC-1), then arithmetic shift right by COEF_FRAC (round half toward +inf).
  - Saturate to the signed OUT_WIDTH range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - OUT: register data_o, pulse val_o for one cycle, return to IDLE.
- Latency: with the accepting cycle as cycle 0, val_o is high at cycle NTAPS+3, counted in en_i-high cycles.
  - busy_o is high for cycles 1..NTAPS+2 and low in the val_o cycle.
  - A new sample can be accepted in the val_o cycle, so minimum input spacing is NTAPS+3 cycles.
- Coefficient writes:
  - Accepted only when state=IDLE and coef_we_i=1; ignored when busy_o=1.
  - An accepted write is written at coef_addr_i the same cycle.
  - If a coefficient write and a sample acceptance occur in the same cycle, the write completes first and the new value is used.
  - Writes with coef_addr_i >= NTAPS are ignored.
  - Coefficient writes do not require en_i.
- en_i low mid-MAC: the computation pauses without corruption and resumes when en_i returns high. Latency stretches by the number of paused cycles.

Test Plan:
- Reset passthrough (NTAPS=21): after reset, input 1000 -> val_o at cycle 24 with data_o=1000. Input -32768 -> data_o=-32768.
- Impulse response: load coef[k]=(k+1)*4096; input 32 then 20 zeros spaced 24 cycles apart -> data_o sequence 1,2,...,21.
- Rounding: coef[0]=65536, others 0.
  - Input 3 -> data_o=2.
  - Input -3 -> data_o=-1.
  - Input 5 -> data_o=3.
- Saturation: all coefs=131071; constant input 32767 for 21 samples -> data_o saturates at 32767. Constant input -32768 -> data_o=-32768.
- Overrun and write lock: val_i again 5 cycles after an accepted sample -> overrun_o pulses once and the first result is unchanged. A coefficient write during busy_o has no effect on the current or next output.
- en_i low 7 cycles mid-MAC -> val_o at cycle 31 with the correct value.
- Reset asserted mid-MAC -> no val_o; busy_o=0 the next cycle; the following impulse test shows a cleared delay line.

Source files
------------

// File: rtl/cic_comp_fir.sv
// Droop-compensation FIR behind the CIC decimator: one shared multiplier walks
// NTAPS taps per accepted sample, then rounds, saturates and strobes the result.
module cic_comp_fir #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int COEF_WIDTH = 18,
  parameter int COEF_FRAC  = 17,
  parameter int NTAPS      = 21,
  parameter int AW         = $clog2(NTAPS),
  parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(NTAPS)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic                         val_i,
  input  logic                         coef_we_i,
  input  logic        [AW-1:0]         coef_addr_i,
  input  logic signed [COEF_WIDTH-1:0] coef_data_i,
  output logic signed [OUT_WIDTH-1:0]  data_o,
  output logic                         val_o,
  output logic                         busy_o,
  output logic                         overrun_o
);

  localparam int PW = DATA_WIDTH + COEF_WIDTH;
  localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);
  localparam logic [AW:0]   NT   = (AW + 1)'(NTAPS);
  localparam logic signed [COEF_WIDTH-1:0] COEF_ONE = COEF_WIDTH'((longint'(1) <<< COEF_FRAC) - 1);
  localparam logic signed [ACC_WIDTH:0] HALF   = (ACC_WIDTH + 1)'(longint'(1) <<< (COEF_FRAC - 1));
  localparam logic signed [ACC_WIDTH:0] SAT_HI = (ACC_WIDTH + 1)'((longint'(1) <<< (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_OUT} state_t;

  state_t                         state_q;
  logic        [AW-1:0]           wptr_q, rptr_q, tap_q;
  logic        [AW-1:0]           wptr_d, rptr_d;
  logic signed [DATA_WIDTH-1:0]   dl_q   [NTAPS];
  logic signed [COEF_WIDTH-1:0]   coef_q [NTAPS];
  logic signed [PW-1:0]           prod_d, prod_p1_q;
  logic signed [ACC_WIDTH-1:0]    prod_ext, acc_p2_q;
  logic signed [OUT_WIDTH-1:0]    data_q;
  logic                           val_q, ovr_q, coef_wr;

  // Round half toward +inf, then clamp to the signed output range.
  function automatic logic signed [OUT_WIDTH-1:0] rnd_sat(input logic signed [ACC_WIDTH-1:0] a);
    logic signed [ACC_WIDTH:0] t;
    t = $signed({a[ACC_WIDTH-1], a}) + HALF;
    t = t >>> COEF_FRAC;
    if (t > SAT_HI)      rnd_sat = SAT_HI[OUT_WIDTH-1:0];
    else if (t < SAT_LO) rnd_sat = SAT_LO[OUT_WIDTH-1:0];
    else                 rnd_sat = t[OUT_WIDTH-1:0];
  endfunction

  always_comb begin
    wptr_d   = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
    rptr_d   = (rptr_q == '0) ? LAST : rptr_q - 1'b1;
    prod_d   = PW'(coef_q[tap_q]) * PW'(dl_q[rptr_q]);
    prod_ext = ACC_WIDTH'(prod_p1_q);
    coef_wr  = coef_we_i && (state_q == S_IDLE) && ({1'b0, coef_addr_i} < NT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      tap_q   <= '0;
      data_q  <= '0;
      val_q   <= 1'b0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        dl_q[i]   <= '0;
        coef_q[i] <= (i == 0) ? COEF_ONE : '0;
      end
    end else begin
      // Coefficient port is independent of the clock enable.
      if (coef_wr) coef_q[coef_addr_i] <= coef_data_i;
      if (en_i) begin
        val_q <= 1'b0;
        ovr_q <= val_i && (state_q != S_IDLE);
        case (state_q)
          S_IDLE: if (val_i) begin
            dl_q[wptr_q] <= data_i;
            rptr_q       <= wptr_q;
            wptr_q       <= wptr_d;
            tap_q        <= '0;
            state_q      <= S_MAC;
          end
          S_MAC: begin
            rptr_q <= rptr_d;
            tap_q  <= tap_q + 1'b1;
            if (tap_q == LAST) state_q <= S_ROUND;
          end
          S_ROUND: state_q <= S_OUT;
          S_OUT: begin
            data_q  <= rnd_sat(acc_p2_q);
            val_q   <= 1'b1;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Stage p1: tap product; stage p2: accumulate, cleared on the first tap.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (state_q == S_MAC) begin
        prod_p1_q <= prod_d;
        acc_p2_q  <= (tap_q == '0) ? '0 : acc_p2_q + prod_ext;
      end else if (state_q == S_ROUND) begin
        acc_p2_q  <= acc_p2_q + prod_ext;
      end
    end
  end

  assign data_o    = data_q;
  assign val_o     = val_q;
  assign busy_o    = (state_q != S_IDLE);
  assign overrun_o = ovr_q;

endmodule
